// File: rtl/sync_fifo_pkg.sv
// Shared constants for the synchronous FIFO slice.
package sync_fifo_pkg;

    // Default number of entries (power of two, at least 4).
    localparam int unsigned SYNC_FIFO_DEFAULT_DEPTH = 32'd8;

    // Default data bits per entry.
    localparam int unsigned SYNC_FIFO_DEFAULT_WIDTH = 32'd8;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// Storage array for the synchronous FIFO: one write port and one registered
// read port. The array and the read register are deliberately not reset.
module sync_fifo_mem #(
    parameter int unsigned DEPTH  = 32'd8,
    parameter int unsigned WIDTH  = 32'd8,
    parameter int unsigned ADDR_W = 32'd3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Write port: store the incoming word when the write is enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port: capture the addressed word only on an enabled read, hold otherwise.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule : sync_fifo_mem

// File: rtl/sync_fifo_top.sv
// Single-clock FIFO: pointers, occupancy count, accept logic and status flags.
// Reset is synchronous and active-high on the port named rstn.
module sync_fifo_top
    import sync_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = SYNC_FIFO_DEFAULT_DEPTH,
    parameter int unsigned FIFO_WIDTH = SYNC_FIFO_DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wren,
    input  logic [FIFO_WIDTH-1:0] wrdata,
    input  logic                  rden,
    output logic [FIFO_WIDTH-1:0] rddata,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 32'd1;

    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFUL = CNT_W'(FIFO_DEPTH - 32'd1);

    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_nxt_s;
    logic                  rd_valid_r;
    logic                  wr_ok_s;
    logic                  rd_ok_s;
    logic                  full_s;
    logic                  empty_s;
    logic [FIFO_WIDTH-1:0] mem_rd_data_s;

    // Flags come from the count register only, so no input reaches an output combinationally.
    always_comb begin
        full_s       = (count_r == CNT_FULL);
        empty_s      = (count_r == CNT_ZERO);
        full         = full_s;
        empty        = empty_s;
        almost_full  = (count_r >= CNT_AFUL);
        almost_empty = (count_r <= CNT_ONE);
    end

    // Accept logic: a write needs space, a read needs data.
    always_comb begin
        wr_ok_s = wren && !full_s;
        rd_ok_s = rden && !empty_s;
    end

    // Next occupancy: simultaneous accepted write and read leave the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, count and read-valid state; reset discards everything that was queued.
    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            rd_valid_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                rd_valid_r <= 1'b1;
            end
            count_r <= count_nxt_s;
        end
    end

    // The storage read register has no reset; rddata reads as zero until the
    // first accepted read after reset reloads it.
    always_comb begin
        if (rd_valid_r) begin
            rddata = mem_rd_data_s;
        end else begin
            rddata = {FIFO_WIDTH{1'b0}};
        end
    end

    sync_fifo_mem #(
        .DEPTH  (FIFO_DEPTH),
        .WIDTH  (FIFO_WIDTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_ok_s && !rstn),
        .wr_addr (wr_ptr_r),
        .wr_data (wrdata),
        .rd_en   (rd_ok_s && !rstn),
        .rd_addr (rd_ptr_r),
        .rd_data (mem_rd_data_s)
    );

endmodule : sync_fifo_top

// File: tb/tb_sync_fifo_top.sv
// Directed self-checking bench for sync_fifo_top (depth 8, width 8).
module tb_sync_fifo_top;

    logic       clk;
    logic       rstn;
    logic       wren;
    logic [7:0] wrdata;
    logic       rden;
    logic [7:0] rddata;
    logic       full;
    logic       almost_full;
    logic       empty;
    logic       almost_empty;

    int         checks_cnt;
    int         errors_cnt;

    // Reference queue and expected read register.
    logic [7:0] ref_q[$];
    logic [7:0] exp_rd;

    sync_fifo_top #(
        .FIFO_DEPTH (32'd8),
        .FIFO_WIDTH (32'd8)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wren         (wren),
        .wrdata       (wrdata),
        .rden         (rden),
        .rddata       (rddata),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {full, almost_full, empty, almost_empty} for an occupancy of n.
    function automatic logic [3:0] flags_for(input int n);
        return {(n == 8), (n >= 7), (n == 0), (n <= 1)};
    endfunction

    // One clock: drive inputs, update the reference, then check outputs after the edge.
    task automatic step(input logic rs, input logic w, input logic [7:0] d, input logic r);
        int  n_before;
        rstn   = rs;
        wren   = w;
        wrdata = d;
        rden   = r;
        n_before = ref_q.size();
        if (rs) begin
            ref_q.delete();
            exp_rd = 8'h00;
        end else begin
            if (r && (n_before != 0)) begin
                exp_rd = ref_q.pop_front();
            end
            if (w && (n_before != 8)) begin
                ref_q.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        check_val("rddata", {24'd0, rddata}, {24'd0, exp_rd});
        check_val("flags", {28'd0, full, almost_full, empty, almost_empty},
                  {28'd0, flags_for(ref_q.size())});
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        exp_rd     = 8'h00;
        rstn       = 1'b1;
        wren       = 1'b0;
        wrdata     = 8'h00;
        rden       = 1'b0;

        // Reset state.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check_val("rst_empty", {31'd0, empty}, 32'd1);
        check_val("rst_rddata", {24'd0, rddata}, 32'h0);

        // Fill with 0x11..0x88.
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b1, 8'(k * 8'h11), 1'b0);
            if (k == 1) check_val("empty_after_1st", {31'd0, empty}, 32'd0);
            if (k == 7) check_val("afull_after_7th", {30'd0, almost_full, full}, 32'd2);
        end
        check_val("full_after_8th", {31'd0, full}, 32'd1);

        // Write while full is dropped.
        step(1'b0, 1'b1, 8'hFF, 1'b0);
        check_val("full_drop", {31'd0, full}, 32'd1);

        // Drain in order.
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            check_val("drain_data", {24'd0, rddata}, k * 32'h11);
            if (k == 7) check_val("aempty_after_7th", {30'd0, almost_empty, empty}, 32'd2);
        end
        check_val("empty_after_8th", {31'd0, empty}, 32'd1);

        // Reads while empty are ignored.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check_val("empty_read_hold", {24'd0, rddata}, 32'h88);

        // Hold 4 entries, then read and write together across the pointer wrap.
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, 8'(k), 1'b0);
        end
        for (int k = 5; k <= 14; k++) begin
            step(1'b0, 1'b1, 8'(k), 1'b1);
            check_val("stream_data", {24'd0, rddata}, 32'(k - 4));
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check_val("stream_last", {24'd0, rddata}, 32'h0E);

        // Full with both requests: read accepted, write dropped.
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b1, 8'(8'h30 + k), 1'b0);
        end
        step(1'b0, 1'b1, 8'hEE, 1'b1);
        check_val("full_both_data", {24'd0, rddata}, 32'h31);
        check_val("full_both_afull", {30'd0, almost_full, full}, 32'd2);
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check_val("full_both_last", {24'd0, rddata}, 32'h38);

        // Reset mid-operation with 5 entries and both requests asserted.
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1, 8'(8'h20 + k), 1'b0);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h77, 1'b1);
        check_val("midrst_empty", {31'd0, empty}, 32'd1);
        check_val("midrst_rddata", {24'd0, rddata}, 32'h0);

        // Empty with both requests: write accepted, read ignored.
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        check_val("empty_both_rd", {24'd0, rddata}, 32'h0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_val("a5_readback", {24'd0, rddata}, 32'hA5);
        check_val("a5_empty", {31'd0, empty}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule : tb_sync_fifo_top
